// File: rtl/hack_data_mem_if.sv
// Hack CPU data-port bundle: the CPU memory bus (addressM/outM/writeM/inM),
// the keyboard valid/ready input stream and the TX valid/ready output stream.
//   master : environment side (CPU, keyboard source, TX sink)
//   slave  : hack_data_mem side
interface hack_data_mem_if;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addressM, outM, writeM, key_data, key_valid, tx_ready,
        input  inM, key_ready, tx_data, tx_valid
    );

    modport slave (
        input  addressM, outM, writeM, key_data, key_valid, tx_ready,
        output inM, key_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/hack_data_mem.sv
// Data-side responder for the Hack CPU memory port.
// RAM at 0x0000..RAM_WORDS-1, plus I/O registers:
//   0x6000 KBD    : keyboard latch (read code / write clears)
//   0x6001 TXDATA : write pushes into TX FIFO, reads 0
//   0x6002 STATUS : {12'b0, ovf, kbd_full, tx_empty, tx_full}, write clears ovf
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : slave side of hack_data_mem_if (CPU bus, key stream, TX stream)
module hack_data_mem #(
    parameter int RAM_WORDS = 16384,
    parameter int TX_DEPTH  = 8
) (
    input logic            clk,
    input logic            reset,
    hack_data_mem_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [14:0] KBD_ADDR  = 15'h6000;
    localparam logic [14:0] TXD_ADDR  = 15'h6001;
    localparam logic [14:0] STAT_ADDR = 15'h6002;

    logic [14:0] a;
    logic        unused_bits;
    logic        is_ram;
    logic        ram_wr, kbd_wr, txd_wr, stat_wr;

    // Bit 15 of the CPU address plays no part in decode.
    assign a           = bus.addressM[14:0];
    assign unused_bits = bus.addressM[15];
    assign is_ram      = {17'd0, a} < 32'(RAM_WORDS);

    // Reset discards any CPU write in the same cycle.
    assign ram_wr  = bus.writeM & ~reset & is_ram;
    assign kbd_wr  = bus.writeM & ~reset & (a == KBD_ADDR);
    assign txd_wr  = bus.writeM & ~reset & (a == TXD_ADDR);
    assign stat_wr = bus.writeM & ~reset & (a == STAT_ADDR);

    // ---------------- RAM (not reset) ----------------
    logic [15:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_wr) ram[a[AW-1:0]] <= bus.outM;
    end

    // ---------------- TX FIFO ----------------
    logic [15:0] fifo [TX_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          tx_full, tx_empty, push, pop, ovf_set, ovf;

    assign tx_full  = (count == (PW+1)'(TX_DEPTH));
    assign tx_empty = (count == '0);
    assign pop      = ~tx_empty & bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push     = txd_wr & (~tx_full | pop);
    assign ovf_set  = txd_wr & tx_full & ~pop;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.outM;
    end

    // ---------------- KBD latch ----------------
    logic        kbd_full;
    logic [15:0] kbd_code;
    logic        key_take;

    // A CPU write to KBD wins over a key handshake in the same cycle.
    assign key_take = bus.key_valid & ~kbd_full & ~kbd_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            kbd_full <= 1'b0;
            kbd_code <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (stat_wr) ovf <= 1'b0;
            if (kbd_wr) begin
                kbd_full <= 1'b0;
                kbd_code <= '0;
            end else if (key_take) begin
                kbd_full <= 1'b1;
                kbd_code <= bus.key_data;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.key_ready = ~kbd_full;
    assign bus.tx_valid  = ~tx_empty;
    assign bus.tx_data   = tx_empty ? 16'h0000 : fifo[rd_ptr];

    logic [15:0] in_m;
    always_comb begin
        in_m = 16'h0000;
        if (is_ram) begin
            in_m = ram[a[AW-1:0]];
        end else begin
            case (a)
                KBD_ADDR:  in_m = kbd_full ? kbd_code : 16'h0000;
                STAT_ADDR: in_m = {12'd0, ovf, kbd_full, tx_empty, tx_full};
                default:   in_m = 16'h0000;
            endcase
        end
    end
    assign bus.inM = in_m;
endmodule
